main_ctrl_fsm: RTL and testbench

Multi-cycle MIPS main control unit and the upstream producer of the 2-bit ALU_op code consumed by the ALU control decoder. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and muxes. It waits on a memory-ready handshake and counts retired fetches. ALU_op encoding: 00=add, 01=branch compare (decoder resolves beq/bne from opcode), 10=R-type by funct, 11=I-type by opcode.

---
 rtl/main_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath controls and counts retired instruction fetches.
module main_ctrl_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             branch_eq,
   output logic             branch_ne,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       ALU_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StRExec  = 4'd7,
      StRWb    = 4'd8,
      StBranch = 4'd9,
      StIExec  = 4'd10,
      StIWb    = 4'd11,
      StJump   = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2b;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAndi  = 6'h0c;
   localparam logic [5:0] OpJ     = 6'h02;

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Branch gating on the zero flag happens outside this block.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      pc_write   = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ALU_op     = 2'b00;
      pc_source  = 2'b00;
      illegal_op = 1'b0;

      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = StDecode;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            op_d      = opcode;
            case (opcode)
               OpRtype:        state_d = StRExec;
               OpLw, OpSw:     state_d = StMemAdr;
               OpBeq, OpBne:   state_d = StBranch;
               OpAddi, OpAndi: state_d = StIExec;
               OpJ:            state_d = StJump;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op_q == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = StFetch;
         end
         StRExec: begin
            alu_src_a = 1'b1;
            ALU_op    = 2'b10;
            state_d   = StRWb;
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            ALU_op    = 2'b10;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            ALU_op    = 2'b01;
            pc_source = 2'b01;
            branch_eq = (op_q == OpBeq);
            branch_ne = (op_q == OpBne);
            state_d   = StFetch;
         end
         StIExec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ALU_op    = 2'b11;
            state_d   = StIWb;
         end
         StIWb: begin
            reg_write = 1'b1;
            ALU_op    = 2'b11;
            state_d   = StFetch;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = StFetch;
         end
         // Unused encodings recover by refetching.
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= 6'h00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed scenarios plus a random instruction
// stream checked against a per-instruction state-path model.
module tb_main_ctrl_fsm;

   localparam logic [5:0] OpR = 6'h00, OpLw = 6'h23, OpSw = 6'h2b, OpBeq = 6'h04;
   localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpAndi = 6'h0c, OpJ = 6'h02;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, ALU_op, pc_source;
   logic [31:0] instr_count;
   logic [3:0]  state;
   logic [17:0] outs;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int         st;
      logic       mr;
      logic [5:0] opc;
   } step_t;
   step_t plan_q[$];

   main_ctrl_fsm #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_op(ALU_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .instr_count(instr_count),
      .state(state)
   );

   always #5 clk = ~clk;

   assign outs = {pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALU_op, pc_source,
                  illegal_op};

   // Drive one cycle's inputs just after the edge, then settle to the falling edge.
   task automatic cyc(input logic mr, input logic [5:0] opc, input logic rst);
      @(posedge clk);
      #1;
      mem_ready = mr;
      opcode    = opc;
      reset     = rst;
      @(negedge clk);
   endtask

   function automatic bit is_legal(input logic [5:0] opc);
      return opc inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAndi, OpJ};
   endfunction

   // Control word each state is documented to produce.
   function automatic logic [17:0] exp_out(input int st, input logic [5:0] opq,
                                           input logic [5:0] opc, input logic mr);
      logic pcw, beq, bne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
      logic [1:0] asb, aop, psrc;
      {pcw, beq, bne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
      {asb, aop, psrc} = '0;
      case (st)
         1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         2:  begin asb = 2'b11; ill = !is_legal(opc); end
         3:  begin asa = 1; asb = 2'b10; end
         4:  begin mrd = 1; iod = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mwr = 1; iod = 1; end
         7:  begin asa = 1; aop = 2'b10; end
         8:  begin rw = 1; rdst = 1; aop = 2'b10; end
         9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; beq = (opq == OpBeq);
                   bne = (opq == OpBne); end
         10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
         11: begin rw = 1; aop = 2'b11; end
         12: begin pcw = 1; psrc = 2'b10; end
         default: ;
      endcase
      return {pcw, beq, bne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
   endfunction

   // Expand one instruction into its expected sequence of (state, mem_ready, opcode).
   task automatic plan_instr(input logic [5:0] opc, input int fw, input int mw);
      for (int i = 0; i <= fw; i++) plan_q.push_back('{st: 1, mr: (i == fw), opc: 6'($urandom)});
      plan_q.push_back('{st: 2, mr: 1'($urandom), opc: opc});
      case (opc)
         OpR:          begin plan_q.push_back('{7, 1'($urandom), 6'($urandom)});
                             plan_q.push_back('{8, 1'($urandom), 6'($urandom)}); end
         OpLw, OpSw: begin
            plan_q.push_back('{3, 1'($urandom), 6'($urandom)});
            for (int i = 0; i <= mw; i++)
               plan_q.push_back('{(opc == OpLw) ? 4 : 6, (i == mw), 6'($urandom)});
            if (opc == OpLw) plan_q.push_back('{5, 1'($urandom), 6'($urandom)});
         end
         OpBeq, OpBne: plan_q.push_back('{9, 1'($urandom), 6'($urandom)});
         OpAddi, OpAndi: begin plan_q.push_back('{10, 1'($urandom), 6'($urandom)});
                               plan_q.push_back('{11, 1'($urandom), 6'($urandom)}); end
         OpJ:          plan_q.push_back('{12, 1'($urandom), 6'($urandom)});
         default: ;
      endcase
   endtask

   task automatic test_reset();
      cyc(1'b0, 6'h00, 1'b1);
      cyc(1'b0, 6'h00, 1'b0);
      n_chk++; if (state !== 4'd0) begin n_fail++;
         $display("FAIL reset_state: got %0d want 0", state); end
      n_chk++; if (outs !== 18'h0) begin n_fail++;
         $display("FAIL reset_outs: got %h want 0", outs); end
      n_chk++; if (instr_count !== 32'd0) begin n_fail++;
         $display("FAIL reset_count: got %0d want 0", instr_count); end
      cyc(1'b0, 6'h00, 1'b0);
      n_chk++; if (state !== 4'd1) begin n_fail++;
         $display("FAIL reset_to_fetch: got %0d want 1", state); end
   endtask

   task automatic test_rtype();
      int st [6] = '{0, 1, 2, 7, 8, 1};
      logic mr [6] = '{0, 1, 1, 1, 1, 0};
      cyc(1'b0, OpR, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(mr[i], OpR, 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, st[i]); end
         n_chk++; if (ALU_op !== ((st[i] == 7 || st[i] == 8) ? 2'b10 : 2'b00)) begin n_fail++;
            $display("FAIL rtype_aluop[%0d]: got %b", i, ALU_op); end
         n_chk++; if ({reg_write, reg_dst} !== {2{st[i] == 8}}) begin n_fail++;
            $display("FAIL rtype_regwr[%0d]: got %b%b", i, reg_write, reg_dst); end
      end
      n_chk++; if (instr_count !== 32'd1) begin n_fail++;
         $display("FAIL rtype_count: got %0d want 1", instr_count); end
   endtask

   task automatic test_lw_wait();
      int st [9] = '{0, 1, 2, 3, 4, 4, 4, 5, 1};
      logic mr [9] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
      int n_mrd = 0;
      int n_rw = 0;
      cyc(1'b0, OpLw, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cyc(mr[i], (i <= 2) ? OpLw : OpR, 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]); end
         if (mem_read && i_or_d) n_mrd++;
         if (reg_write) begin
            n_rw++;
            n_chk++; if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin n_fail++;
               $display("FAIL lw_wb_mux: got m2r=%b dst=%b want 1/0", mem_to_reg, reg_dst); end
         end
      end
      n_chk++; if (n_mrd != 3) begin n_fail++;
         $display("FAIL lw_memrd_cycles: got %0d want 3", n_mrd); end
      n_chk++; if (n_rw != 1) begin n_fail++;
         $display("FAIL lw_regwrite_pulses: got %0d want 1", n_rw); end
   endtask

   task automatic test_branch();
      int st [8] = '{0, 1, 2, 9, 1, 2, 9, 1};
      logic mr [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
      logic [5:0] opc [8] = '{6'h3f, 6'h3f, OpBne, 6'h3f, 6'h3f, OpBeq, 6'h05, 6'h3f};
      cyc(1'b0, 6'h3f, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(mr[i], opc[i], 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL br_state[%0d]: got %0d want %0d", i, state, st[i]); end
         n_chk++; if (reg_write !== 1'b0) begin n_fail++;
            $display("FAIL br_regwrite[%0d]: got 1 want 0", i); end
         if (st[i] == 9) begin
            n_chk++; if ({ALU_op, pc_source} !== 4'b0101) begin n_fail++;
               $display("FAIL br_aluop_psrc[%0d]: got %b %b want 01 01", i, ALU_op, pc_source); end
            n_chk++; if ({branch_eq, branch_ne} !== ((i == 3) ? 2'b01 : 2'b10)) begin n_fail++;
               $display("FAIL br_eq_ne[%0d]: got %b%b", i, branch_eq, branch_ne); end
         end
      end
   endtask

   task automatic test_fetch_wait_illegal();
      int st [7] = '{0, 1, 1, 1, 1, 2, 1};
      logic mr [7] = '{0, 0, 0, 0, 1, 0, 0};
      int n_irw = 0;
      int n_pcw = 0;
      cyc(1'b0, 6'h3f, 1'b1);
      for (int i = 0; i < 7; i++) begin
         cyc(mr[i], 6'h3f, 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL ill_state[%0d]: got %0d want %0d", i, state, st[i]); end
         n_chk++; if (illegal_op !== (st[i] == 2)) begin n_fail++;
            $display("FAIL ill_pulse[%0d]: got %b", i, illegal_op); end
         n_chk++; if ({reg_write, mem_write} !== 2'b00) begin n_fail++;
            $display("FAIL ill_nowrite[%0d]: got %b%b want 00", i, reg_write, mem_write); end
         n_irw += int'(ir_write);
         n_pcw += int'(pc_write);
      end
      n_chk++; if (n_irw != 1 || n_pcw != 1) begin n_fail++;
         $display("FAIL ill_fetch_pulses: got ir=%0d pc=%0d want 1 1", n_irw, n_pcw); end
      n_chk++; if (instr_count !== 32'd1) begin n_fail++;
         $display("FAIL ill_count: got %0d want 1", instr_count); end
   endtask

   task automatic test_addi_j();
      int st [9] = '{0, 1, 2, 10, 11, 1, 2, 12, 1};
      logic mr [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
      logic [5:0] opc [9] = '{6'h3f, 6'h3f, OpAddi, 6'h3f, 6'h3f, 6'h3f, OpJ, 6'h3f, 6'h3f};
      cyc(1'b0, 6'h3f, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cyc(mr[i], opc[i], 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL ij_state[%0d]: got %0d want %0d", i, state, st[i]); end
         if (st[i] == 10) begin
            n_chk++; if ({ALU_op, alu_src_b} !== 4'b1110) begin n_fail++;
               $display("FAIL ij_iexec: got aluop=%b srcb=%b want 11 10", ALU_op, alu_src_b); end
         end
         if (st[i] == 11) begin
            n_chk++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin n_fail++;
               $display("FAIL ij_iwb: got %b%b%b want 100", reg_write, reg_dst, mem_to_reg); end
         end
         if (st[i] == 12) begin
            n_chk++; if ({pc_write, pc_source} !== 3'b110) begin n_fail++;
               $display("FAIL ij_jump: got pcw=%b psrc=%b want 1 10", pc_write, pc_source); end
         end
      end
      n_chk++; if (instr_count !== 32'd2) begin n_fail++;
         $display("FAIL ij_count: got %0d want 2", instr_count); end
   endtask

   task automatic test_reset_mid_sw();
      int st [6] = '{0, 1, 2, 3, 6, 6};
      logic mr [6] = '{0, 1, 0, 0, 0, 0};
      cyc(1'b0, OpSw, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(mr[i], OpSw, 1'b0);
         n_chk++; if (state !== 4'(st[i])) begin n_fail++;
            $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      end
      n_chk++; if ({mem_write, i_or_d} !== 2'b11) begin n_fail++;
         $display("FAIL sw_memwr: got %b%b want 11", mem_write, i_or_d); end
      cyc(1'b0, OpSw, 1'b1);
      cyc(1'b1, OpSw, 1'b0);
      n_chk++; if (state !== 4'd0 || mem_write !== 1'b0 || instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL sw_reset: got st=%0d mw=%b cnt=%0d want 0 0 0", state, mem_write,
                  instr_count);
      end
      cyc(1'b0, OpSw, 1'b0);
      n_chk++; if (state !== 4'd1) begin n_fail++;
         $display("FAIL sw_resume: got %0d want 1", state); end
   endtask

   task automatic test_random_program();
      logic [5:0] legal [8] = '{OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAndi, OpJ};
      logic [5:0] cur_op = 6'h00;
      logic [31:0] model_cnt = 32'd0;
      logic [17:0] exp;
      step_t s;
      plan_q.delete();
      for (int n = 0; n < 80; n++) begin
         logic [5:0] opc = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)]
                                                      : 6'($urandom);
         plan_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      cyc(1'b0, 6'h00, 1'b1);
      cyc(1'b0, 6'h00, 1'b0);
      while (plan_q.size() > 0) begin
         s = plan_q.pop_front();
         cyc(s.mr, s.opc, 1'b0);
         if (s.st == 2) cur_op = s.opc;
         exp = exp_out(s.st, cur_op, s.opc, s.mr);
         n_chk++; if (state !== 4'(s.st)) begin n_fail++;
            $display("FAIL rnd_state: got %0d want %0d", state, s.st); end
         n_chk++; if (outs !== exp) begin n_fail++;
            $display("FAIL rnd_outs (st %0d op %h): got %h want %h", s.st, cur_op, outs, exp); end
         n_chk++; if (instr_count !== model_cnt) begin n_fail++;
            $display("FAIL rnd_count: got %0d want %0d", instr_count, model_cnt); end
         if (s.st == 1 && s.mr) model_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_fetch_wait_illegal();
      test_addi_j();
      test_reset_mid_sw();
      test_random_program();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
